// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - instruction-memory and decode handshake bundle for the fetch queue
interface fetch_queue_if;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic        id_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output id_valid, id_pc, id_instr,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  id_valid, id_pc, id_instr,
    output id_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction fetch queue with slot allocation at issue and flush on redirect
module fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [63:0]    pc_in,
  output logic           pc_advance,
  input  logic           redirect,
  fetch_queue_if.master  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  // Stale responses can pile up across back-to-back redirects, so the drop counter is wider than the queue.
  localparam int DW = 8;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] PONE    = PW'(1);
  localparam logic [DW-1:0] DONE    = DW'(1);

  logic [63:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0]    count_q, count_d, outst_q, outst_d;
  logic [DW-1:0]    drop_q, drop_d, unret;
  logic             issue, pop, resp_take, resp_drop;

  always_comb begin
    bus.imem_req_valid = reset_n && (count_q < DEPTH_C) && !redirect;
    bus.imem_req_addr  = pc_in;
    issue              = bus.imem_req_valid && bus.imem_req_ready;
    pc_advance         = issue;
    bus.id_valid       = filled_q[head_q] && (count_q != '0);
    bus.id_pc          = pc_q[head_q];
    bus.id_instr       = instr_q[head_q];
    pop                = bus.id_valid && bus.id_ready;
    resp_take          = bus.imem_resp_valid && (drop_q == '0) && !redirect && (outst_q != '0);
    resp_drop          = bus.imem_resp_valid && (drop_q != '0) && !redirect;
    unret              = DW'(outst_q) + drop_q;
  end

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    fill_d   = fill_q;
    count_d  = count_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    filled_d = filled_q;
    if (redirect) begin
      count_d  = '0;
      outst_d  = '0;
      head_d   = tail_q;
      fill_d   = tail_q;
      filled_d = '0;
      drop_d   = (bus.imem_resp_valid && (unret != '0)) ? unret - DONE : unret;
    end else begin
      if (resp_take) begin
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PONE;
      end
      if (resp_drop) drop_d = drop_q - DONE;
      if (pop) head_d = head_q + PONE;
      if (issue) begin
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PONE;
      end
      count_d = count_q + CW'(issue) - CW'(pop);
      outst_d = outst_q + CW'(issue) - CW'(resp_take);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
      filled_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      fill_q   <= fill_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      filled_q <= filled_d;
    end
  end

  // Payload storage is qualified by the filled bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (issue)     pc_q[tail_q]    <= pc_in;
    if (resp_take) instr_q[fill_q] <= bus.imem_resp_data;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
- REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of in-flight-plus-buffered fetch slots (power of two, 2..8).
- REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
- REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
- REQ-004 SHALL have port pc_in  input  64  current PC from the program-counter register.
- REQ-005 SHALL have port pc_advance  output  1  pulse telling the PC stage to load the next PC this cycle.
- REQ-006 SHALL have port imem_req_valid  output  1  instruction-memory request valid.
- REQ-007 SHALL have port imem_req_addr  output  64  instruction-memory request byte address.
- REQ-008 SHALL have port imem_req_ready  input  1  instruction memory accepts a request.
- REQ-009 SHALL have port imem_resp_valid  input  1  instruction-memory response valid, in request order, no back-pressure.
- REQ-010 SHALL have port imem_resp_data  input  32  returned instruction word.
- REQ-011 SHALL have port redirect  input  1  flush request from branch/jump resolution.
- REQ-012 SHALL have port id_valid  output  1  decode-stage entry valid.
- REQ-013 SHALL have port id_pc  output  64  PC of the presented instruction.
- REQ-014 SHALL have port id_instr  output  32  presented instruction word.
- REQ-015 SHALL have port id_ready  input  1  decode stage accepts the presented entry.

Function
- REQ-016 SHALL hold a circular queue of DEPTH slots {pc, instr, filled}, head/tail pointers and a registered occupancy count 0..DEPTH; a slot is allocated at request issue, filled at response.
- REQ-017 SHALL drive imem_req_valid = (count < DEPTH) && !redirect, using the registered count only (no same-cycle credit from a pop).
- REQ-018 SHALL drive imem_req_addr = pc_in, combinationally.
- REQ-019 SHALL define issue = imem_req_valid && imem_req_ready; on issue, write pc_in into the tail slot, clear its filled bit, advance tail modulo DEPTH.
- REQ-020 SHALL drive pc_advance = issue; no other condition asserts it.
- REQ-021 SHALL, on imem_resp_valid with drop_cnt == 0 and no redirect, write imem_resp_data into the oldest unfilled slot and set filled; the fill pointer advances modulo DEPTH.
- REQ-022 SHALL drive id_valid = head slot filled && count > 0; id_pc/id_instr SHALL reflect the head slot.
- REQ-023 SHALL define pop = id_valid && id_ready; on pop, advance head and decrement count; issue and pop in the same cycle leave count unchanged.
- REQ-024 SHALL, on redirect, in the same edge: empty the queue (count = 0, head = tail = fill pointer), suppress issue, and load drop_cnt with the number of issued-but-unreturned requests, minus one if a response arrives that cycle.
- REQ-025 SHALL, while drop_cnt > 0 and no redirect, discard each imem_resp_valid and decrement drop_cnt; no slot is written.
- REQ-026 SHALL keep id_valid low in the redirect cycle's following cycle until a post-redirect response fills the new head.
- REQ-027 SHALL accept a new issue in the cycle after redirect, even while drop_cnt > 0, provided count < DEPTH.
- REQ-028 SHALL ignore imem_resp_valid when no request is outstanding and drop_cnt == 0.
- REQ-029 SHALL hold id_pc/id_instr stable while id_valid && !id_ready.

Reset
- REQ-030 SHALL, while reset_n is low, force count, head, tail, fill pointer, drop_cnt and all filled bits to 0, making id_valid and pc_advance 0, asynchronously.
- REQ-031 SHALL raise imem_req_valid in the first cycle after reset_n rises, with imem_req_addr = pc_in.
- REQ-032 SHALL discard any response outstanding when reset asserts; the memory side is reset together.

Verification
- REQ-033 SHALL test single-cycle memory: pc_in 0x0, 0x4, 0x8; ready and resp always 1; id_ready 1 -> id_pc 0x0, 0x4, 0x8 on consecutive cycles after one-cycle latency.
- REQ-034 SHALL test back-pressure: id_ready 0 with DEPTH=2 -> exactly 2 issues, then imem_req_valid 0, pc_advance 0; id_pc stays 0x0 until id_ready 1.
- REQ-035 SHALL test redirect: 2 outstanding at 0x10/0x14, redirect with pc_in 0x100 -> both late responses dropped, next id_pc 0x100.
- REQ-036 SHALL test redirect coinciding with a response -> that response is dropped, drop_cnt = outstanding-1.
- REQ-037 SHALL test reset mid-operation: reset_n low with a full queue -> id_valid 0 immediately; after release, the first request is issued at pc_in 0x0.
